// File: rtl/vedic_div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package vedic_div_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned VW_DEF = 8;

  function automatic int unsigned cnt_w(input int unsigned dw);
    return $clog2(dw);
  endfunction

  localparam int unsigned CNT_W = cnt_w(DW_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vedic_div_seq_if.sv
// Request/result bundle between a requester and the divider.
interface vedic_div_seq_if
  import vedic_div_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned VW = VW_DEF
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );
endinterface

// File: rtl/vedic_div_step.sv
// One restoring-division iteration: shift in a bit, trial-subtract, restore on borrow.
module vedic_div_step
  import vedic_div_pkg::*;
#(
  parameter int unsigned VW = VW_DEF
) (
  input  logic [VW:0]   rem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_out,
  output logic          q_bit
);
  logic [VW+1:0] shifted;
  logic [VW+1:0] diff;

  // One extra bit of headroom so the borrow shows up as the diff MSB.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[VW+1];
    rem_out = q_bit ? diff[VW:0] : shifted[VW:0];
  end
endmodule

// File: rtl/vedic_div_seq.sv
// Sequential restoring divider, one quotient bit per clock; FSM, counter and result registers.
module vedic_div_seq
  import vedic_div_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned VW = VW_DEF
) (
  input logic            clk,
  input logic            rst,
  vedic_div_seq_if.slave bus
);
  localparam int unsigned CW = cnt_w(DW);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q;
  logic [DW-1:0] shreg_q;
  logic [VW-1:0] dvsr_q;
  logic [VW:0]   prem_q;
  logic [VW:0]   prem_step;
  logic          q_bit;
  logic          busy_q, done_q, dbz_q;
  logic [DW-1:0] quot_q;
  logic [VW-1:0] rem_q;

  vedic_div_step #(.VW(VW)) u_step (
    .rem_in  (prem_q),
    .bit_in  (shreg_q[DW-1]),
    .divisor (dvsr_q),
    .rem_out (prem_step),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.divisor == '0) ? DONE : RUN;
      RUN:     if (count_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are the state registered once more, so every output comes from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      shreg_q <= '0;
      dvsr_q  <= '0;
      prem_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      busy_q <= (state_q == RUN);
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            shreg_q <= bus.dividend;
            dvsr_q  <= bus.divisor;
            prem_q  <= '0;
            if (bus.divisor == '0) begin
              dbz_q   <= 1'b1;
              quot_q  <= '1;
              rem_q   <= bus.dividend[VW-1:0];
              count_q <= '0;
            end else begin
              dbz_q   <= 1'b0;
              count_q <= CW'(DW - 1);
            end
          end
        end
        RUN: begin
          shreg_q <= {shreg_q[DW-2:0], q_bit};
          prem_q  <= prem_step;
          if (count_q == '0) begin
            quot_q <= {shreg_q[DW-2:0], q_bit};
            rem_q  <= prem_step[VW-1:0];
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbz       = dbz_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
endmodule
